spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 196 +++++++++++++++++++
 tb/tb_spi_slave.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave with cs/sclk/mosi oversampled on clk.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int DW = DATA_WIDTH;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    ACTIVE
  } state_t;

  state_t r_state;

  logic [SS-1:0] r_cs_sync;
  logic [SS-1:0] r_sclk_sync;
  logic [SS-1:0] r_mosi_sync;
  logic [SS:0]   r_warm;

  logic r_sclk_d;
  logic r_cs_d;
  logic r_ev_srise;
  logic r_ev_sfall;
  logic r_ev_crise;
  logic r_ev_cfall;
  logic r_mosi_q;
  logic r_cs_q;

  logic [DW-1:0] r_tx_buf;
  logic [DW-1:0] r_tx_shift;
  logic [DW-1:0] r_rx_shift;
  logic [CW-1:0] r_bit_cnt;
  logic [DW-1:0] r_data_out;
  logic          r_done;
  logic          r_miso;

  logic          w_cs_s;
  logic          w_sclk_s;
  logic          w_mosi_s;
  logic [DW-1:0] w_tx_src;
  logic [DW-1:0] w_tx_shl;
  logic [DW-1:0] w_rx_next;

  assign w_cs_s   = r_cs_sync[SS-1];
  assign w_sclk_s = r_sclk_sync[SS-1];
  assign w_mosi_s = r_mosi_sync[SS-1];

  // A load landing on a reload cycle must win over the stale buffer.
  assign w_tx_src  = tx_load ? data_in : r_tx_buf;
  assign w_tx_shl  = r_tx_shift << 1;
  assign w_rx_next = (r_rx_shift << 1) | DW'(r_mosi_q);

  assign miso     = r_miso;
  assign data_out = r_data_out;
  assign done     = r_done;
  assign busy     = ~w_cs_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SS-2:0], cs};
      r_sclk_sync <= {r_sclk_sync[SS-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SS-2:0], mosi};
    end
  end

  // r_warm marks when the pipeline holds pin samples taken after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warm     <= '0;
      r_sclk_d   <= 1'b0;
      r_cs_d     <= 1'b1;
      r_ev_srise <= 1'b0;
      r_ev_sfall <= 1'b0;
      r_ev_crise <= 1'b0;
      r_ev_cfall <= 1'b0;
      r_mosi_q   <= 1'b0;
      r_cs_q     <= 1'b1;
    end else begin
      r_warm     <= {r_warm[SS-1:0], 1'b1};
      r_sclk_d   <= w_sclk_s;
      r_cs_d     <= w_cs_s;
      r_ev_srise <= w_sclk_s & ~r_sclk_d;
      r_ev_sfall <= ~w_sclk_s & r_sclk_d;
      r_ev_crise <= w_cs_s & ~r_cs_d;
      r_ev_cfall <= ~w_cs_s & r_cs_d;
      r_mosi_q   <= w_mosi_s;
      r_cs_q     <= w_cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RESYNC;
      r_tx_buf   <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_tx_buf <= w_tx_src;
      unique case (r_state)
        RESYNC: begin
          r_miso <= 1'b0;
          if (r_warm[SS] && r_cs_q) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (r_ev_cfall) begin
            r_state    <= ACTIVE;
            r_tx_shift <= w_tx_src;
            r_miso     <= w_tx_src[DW-1];
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
          end
        end
        ACTIVE: begin
          if (r_ev_crise) begin
            r_state    <= IDLE;
            r_miso     <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
          end else if (r_ev_srise) begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == LAST) begin
              r_data_out <= w_rx_next;
              r_done     <= 1'b1;
              r_bit_cnt  <= '0;
              r_tx_shift <= w_tx_src;
              r_miso     <= w_tx_src[DW-1];
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end else if (r_ev_sfall && r_bit_cnt != '0) begin
            r_tx_shift <= w_tx_shl;
            r_miso     <= w_tx_shl[DW-1];
          end
        end
        default: begin
          r_state <= RESYNC;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_ferr;
  logic w_abort;
  logic w_stray;

  assign w_abort   = (r_state == ACTIVE) && r_ev_crise
                     && (r_bit_cnt != '0);
  assign w_stray   = r_warm[SS] && r_cs_q
                     && (r_ev_srise || r_ev_sfall);
  assign frame_err = r_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= w_abort | w_stray;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus random frames
// checked against a byte-level model of the slave.
module tb_spi_slave;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic          sclk;
  logic          mosi;
  logic          tx_load;
  logic [DW-1:0] data_in;
  logic          miso;
  logic          done;
  logic          busy;
  logic [DW-1:0] data_out;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic          frame_err;
`endif

  int            n_pass  = 0;
  int            n_fail  = 0;
  int            n_total = 0;
  int unsigned   cyc     = 0;
  int            done_cnt = 0;
  int            ferr_cnt = 0;
  int unsigned   last_rise_cyc = 0;
  int unsigned   last_done_cyc = 0;
  logic [DW-1:0] rx_log[$];
  // Model: value the slave must send at the next byte boundary,
  // and the last byte the master completed.
  logic [DW-1:0] model_buf = '0;
  logic [DW-1:0] model_out = '0;

  spi_slave #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .data_in (data_in),
    .tx_load (tx_load),
    .data_out(data_out),
    .done    (done),
    .busy    (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      rx_log.push_back(data_out);
      last_done_cyc = cyc;
    end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err === 1'b1) ferr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [DW-1:0] v);
    data_in   = v;
    tx_load   = 1'b1;
    tick(1);
    tx_load   = 1'b0;
    model_buf = v;
  endtask

  // sclk period 4 clk; miso captured at the end of each high phase.
  task automatic send_bits(input logic [DW-1:0] b, input int nbits,
                           input bit mid_ld, input logic [DW-1:0] ld_v,
                           output logic [DW-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[DW-1-i];
      if (mid_ld && i == 3) begin
        load(ld_v);
        tick(1);
      end else begin
        tick(2);
      end
      sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(2);
      got[DW-1-i] = miso;
      sclk = 1'b0;
    end
  endtask

  task automatic rnd_frame(input int nb);
    logic [DW-1:0] sent[$];
    logic [DW-1:0] b;
    logic [DW-1:0] v;
    logic [DW-1:0] tx_exp;
    logic [DW-1:0] got;
    bit            ml;
    int            d0;
    rx_log.delete();
    d0 = done_cnt;
    cs = 1'b0;
    tick(6);
    for (int k = 0; k < nb; k++) begin
      tx_exp = model_buf;
      b  = DW'($urandom);
      v  = DW'($urandom);
      ml = 1'($urandom_range(0, 1));
      send_bits(b, DW, ml, v, got);
      check("rnd_miso", 32'(got), 32'(tx_exp));
      sent.push_back(b);
      model_out = b;
    end
    tick(6);
    cs = 1'b1;
    tick(8);
    check("rnd_done_cnt", 32'(done_cnt - d0), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      check("rnd_rx", 32'((k < rx_log.size()) ? rx_log[k] : 'x),
            32'(sent[k]));
    end
    check("rnd_dout", 32'(data_out), 32'(model_out));
  endtask

  initial begin
    logic [DW-1:0] got;
    logic [DW-1:0] got2;
    logic          acc;
    int            d0;
    int            f0;

    reset   = 1'b1;
    cs      = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_load = 1'b0;
    data_in = '0;
    tick(3);
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_miso", 32'(miso), 32'(0));
    check("rst_dout", 32'(data_out), 32'(0));
    reset = 1'b0;
    tick(8);
    f0 = ferr_cnt;

    // Single byte 0xA5 in, 0x3C out, with latency check.
    load(8'h3C);
    cs = 1'b0;
    tick(6);
    check("busy_hi", 32'(busy), 32'(1));
    d0 = done_cnt;
    send_bits(8'hA5, DW, 1'b0, '0, got);
    tick(6);
    check("latency", last_done_cyc - last_rise_cyc, 32'(SS + 2));
    cs = 1'b1;
    tick(8);
    check("busy_lo", 32'(busy), 32'(0));
    check("a5_done", 32'(done_cnt - d0), 32'(1));
    check("a5_dout", 32'(data_out), 32'(8'hA5));
    check("a5_miso", 32'(got), 32'(8'h3C));
    model_out = 8'hA5;

    // Aborted byte after 5 bits.
    cs = 1'b0;
    tick(6);
    d0 = done_cnt;
    send_bits(8'hFF, 5, 1'b0, '0, got);
    tick(6);
    cs = 1'b1;
    tick(8);
    check("abort_done", 32'(done_cnt - d0), 32'(0));
    check("abort_dout", 32'(data_out), 32'(8'hA5));
    check("abort_busy", 32'(busy), 32'(0));
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("abort_ferr", 32'(ferr_cnt - f0), 32'(1));
`endif

    // Two bytes in one frame, tx_buf reloaded mid first byte.
    load(8'h11);
    rx_log.delete();
    cs = 1'b0;
    tick(6);
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_bits(8'h01, DW, 1'b1, 8'h11, got);
    send_bits(8'hFE, DW, 1'b0, '0, got2);
    tick(6);
    cs = 1'b1;
    tick(8);
    check("b2b_done", 32'(done_cnt - d0), 32'(2));
    check("b2b_rx0", 32'((rx_log.size() > 0) ? rx_log[0] : 'x), 32'(8'h01));
    check("b2b_rx1", 32'((rx_log.size() > 1) ? rx_log[1] : 'x), 32'(8'hFE));
    check("b2b_miso0", 32'(got), 32'(8'h11));
    check("b2b_miso1", 32'(got2), 32'(8'h11));

    // tx_load on the exact reload cycle must supply the next byte.
    cs = 1'b0;
    tick(6);
    send_bits(8'hC3, DW, 1'b0, '0, got);
    tick(1);
    data_in = 8'h9E;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    send_bits(8'h3A, DW, 1'b0, '0, got2);
    tick(6);
    cs = 1'b1;
    tick(8);
    check("coin_miso0", 32'(got), 32'(8'h11));
    check("coin_miso1", 32'(got2), 32'(8'h9E));
    check("coin_dout", 32'(data_out), 32'(8'h3A));
    model_buf = 8'h9E;
    model_out = 8'h3A;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("clean_ferr", 32'(ferr_cnt - f0), 32'(0));
`endif

    // sclk toggling with cs high is ignored.
    d0  = done_cnt;
    f0  = ferr_cnt;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      sclk = 1'b1;
      tick(3);
      acc |= miso;
      sclk = 1'b0;
      tick(3);
      acc |= miso;
    end
    tick(6);
    check("idle_miso", 32'(acc), 32'(0));
    check("idle_done", 32'(done_cnt - d0), 32'(0));
    check("idle_dout", 32'(data_out), 32'(model_out));
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("idle_ferr", 32'(ferr_cnt != f0), 32'(1));
`endif

    // Reset mid-frame, then clocks with cs still low.
    cs = 1'b0;
    tick(6);
    send_bits(8'hFF, 3, 1'b0, '0, got);
    reset = 1'b1;
    tick(2);
    check("mid_rst_done", 32'(done), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_miso", 32'(miso), 32'(0));
    reset = 1'b0;
    model_buf = '0;
    d0 = done_cnt;
    send_bits(8'hFF, DW, 1'b0, '0, got);
    tick(6);
    check("post_rst_done", 32'(done_cnt - d0), 32'(0));
    check("post_rst_dout", 32'(data_out), 32'(0));
    cs = 1'b1;
    tick(8);
    cs = 1'b0;
    tick(6);
    d0 = done_cnt;
    send_bits(8'h5A, DW, 1'b0, '0, got);
    tick(6);
    cs = 1'b1;
    tick(8);
    check("5a_done", 32'(done_cnt - d0), 32'(1));
    check("5a_dout", 32'(data_out), 32'(8'h5A));
    check("5a_miso", 32'(got), 32'(model_buf));
    model_out = 8'h5A;

    for (int f = 0; f < 6; f++) begin
      rnd_frame($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
